pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/lambo_fetch_pkg.sv | 29 ++
 rtl/pc_sequencer_if.sv | 40 ++++
 rtl/ras_stack.sv | 76 +++++++
 rtl/pc_sequencer.sv | 111 +++++++++++
 tb/tb_pc_sequencer.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/lambo_fetch_pkg.sv
// Shared fetch-unit definitions: sequencer states, branch condition codes and
// the default program base address table.
package lambo_fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_GE     = 2'b01;
    localparam logic [1:0] COND_NGE    = 2'b10;
    localparam logic [1:0] COND_EQ     = 2'b11;

    localparam int unsigned PROG_BASE_N = 3;
    localparam int unsigned PROG_BASE [PROG_BASE_N] = '{0, 100, 200};

    // Indices beyond the table fall back to address 0.
    function automatic int unsigned prog_base(input int unsigned idx);
        case (idx)
            0:       return PROG_BASE[0];
            1:       return PROG_BASE[1];
            2:       return PROG_BASE[2];
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the instruction decoder and the PC sequencer.
interface pc_sequencer_if #(
    parameter int PC_W      = 10,
    parameter int OFF_W     = 5,
    parameter int RAS_DEPTH = 4,
    parameter int NUM_PROG  = 3
);
    localparam int SEL_W = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic                    Start;
    logic [SEL_W-1:0]        ProgSel;
    logic                    Stall;
    logic                    BranchEn;
    logic [1:0]              CondSel;
    logic                    GE_Flag;
    logic                    EQ_Flag;
    logic signed [OFF_W-1:0] BranchOffset;
    logic                    CallEn;
    logic                    RetEn;
    logic                    HaltEn;
    logic [PC_W-1:0]         ProgCtr;
    logic                    Done;
    logic [CNT_W-1:0]        RasCount;
    logic                    RasOvf;
    logic                    RasUnf;

    modport master (
        output Start, ProgSel, Stall, BranchEn, CondSel, GE_Flag, EQ_Flag,
               BranchOffset, CallEn, RetEn, HaltEn,
        input  ProgCtr, Done, RasCount, RasOvf, RasUnf
    );

    modport slave (
        input  Start, ProgSel, Stall, BranchEn, CondSel, GE_Flag, EQ_Flag,
               BranchOffset, CallEn, RetEn, HaltEn,
        output ProgCtr, Done, RasCount, RasOvf, RasUnf
    );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// an empty pop leaves state untouched; both raise sticky flags.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 data_i,
    output logic [W-1:0]                 top_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         ovf_o,
    output logic                         unf_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, ptr_nxt, ptr_prv;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;

    // ptr_q addresses the next free slot, which is also the oldest entry once full.
    assign ptr_nxt = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
    assign ptr_prv = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - PW'(1);
    assign top_o   = mem_q[ptr_prv];
    assign count_o = cnt_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clear_i) begin
            ptr_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (push_i) begin
            ptr_d = ptr_nxt;
            if (cnt_q == CW'(DEPTH)) ovf_d = 1'b1;
            else                     cnt_d = cnt_q + CW'(1);
        end else if (pop_i) begin
            if (cnt_q != '0) begin
                ptr_d = ptr_prv;
                cnt_d = cnt_q - CW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[ptr_q] <= data_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: program load, conditional/relative branches,
// call/return through a circular return stack, and halt.
module pc_sequencer
    import lambo_fetch_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int OFF_W     = 5,
    parameter int RAS_DEPTH = 4,
    parameter int NUM_PROG  = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    pc_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    state_e                 state_q, state_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic [PC_W-1:0]        pc_inc, pc_rel, base, ras_top;
    logic signed [PC_W-1:0] off_ext;
    logic                   cond_ok, taken;
    logic                   push, pop, clr;
    logic [CNT_W-1:0]       ras_cnt;
    logic                   ras_ovf, ras_unf;

    assign off_ext = PC_W'(bus.BranchOffset);
    assign pc_inc  = pc_q + PC_W'(1);
    assign pc_rel  = pc_q + off_ext;
    assign taken   = bus.BranchEn && cond_ok;

    always_comb begin
        base = '0;
        if (int'(bus.ProgSel) < NUM_PROG) base = PC_W'(prog_base(int'(bus.ProgSel)));
    end

    always_comb begin
        case (bus.CondSel)
            COND_ALWAYS: cond_ok = 1'b1;
            COND_GE:     cond_ok = bus.GE_Flag;
            COND_NGE:    cond_ok = !bus.GE_Flag;
            default:     cond_ok = bus.EQ_Flag;
        endcase
    end

    // Start overrides everything; Stall then freezes whatever state we are in.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        if (bus.Start) begin
            state_d = ST_LOAD;
            pc_d    = base;
            clr     = 1'b1;
        end else if (!bus.Stall) begin
            case (state_q)
                ST_LOAD: state_d = ST_RUN;
                ST_RUN: begin
                    if (bus.HaltEn) begin
                        state_d = ST_HALT;
                    end else if (bus.RetEn) begin
                        pop  = 1'b1;
                        pc_d = (ras_cnt != '0) ? ras_top : pc_inc;
                    end else if (bus.CallEn) begin
                        push = 1'b1;
                        pc_d = pc_rel;
                    end else if (taken) begin
                        pc_d = pc_rel;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk     (Clk),
        .rst     (Reset),
        .clear_i (clr),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_inc),
        .top_o   (ras_top),
        .count_o (ras_cnt),
        .ovf_o   (ras_ovf),
        .unf_o   (ras_unf)
    );

    assign bus.ProgCtr  = pc_q;
    assign bus.Done     = (state_q == ST_HALT);
    assign bus.RasCount = ras_cnt;
    assign bus.RasOvf   = ras_ovf;
    assign bus.RasUnf   = ras_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer with default parameters.
module tb_pc_sequencer;
    import lambo_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(10), .OFF_W(5), .RAS_DEPTH(4), .NUM_PROG(3)) bus ();

    pc_sequencer #(.PC_W(10), .OFF_W(5), .RAS_DEPTH(4), .NUM_PROG(3)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       start;
        logic [1:0] sel;
        logic       stall;
        logic       br;
        logic [1:0] cond;
        logic       ge;
        logic       eq;
        logic [4:0] off;
        logic       call;
        logic       ret;
        logic       halt;
        logic [9:0] pc;
        logic [2:0] cnt;
        logic       ovf;
        logic       unf;
        logic       done;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    vec_t vq[$];

    function automatic vec_t mk(logic start, logic [1:0] sel, logic stall, logic br,
                                logic [1:0] cond, logic ge, logic eq, logic [4:0] off,
                                logic call, logic ret, logic halt, logic [9:0] pc,
                                logic [2:0] cnt, logic ovf, logic unf, logic done);
        vec_t v;
        v.start = start; v.sel = sel; v.stall = stall; v.br = br; v.cond = cond;
        v.ge = ge; v.eq = eq; v.off = off; v.call = call; v.ret = ret; v.halt = halt;
        v.pc = pc; v.cnt = cnt; v.ovf = ovf; v.unf = unf; v.done = done;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(string tag, int pc, int cnt, int ovf, int unf, int done);
        chk({tag, " ProgCtr"},  32'(bus.ProgCtr),  pc);
        chk({tag, " RasCount"}, 32'(bus.RasCount), cnt);
        chk({tag, " RasOvf"},   32'(bus.RasOvf),   ovf);
        chk({tag, " RasUnf"},   32'(bus.RasUnf),   unf);
        chk({tag, " Done"},     32'(bus.Done),     done);
    endtask

    task automatic drive(vec_t v);
        bus.Start = v.start; bus.ProgSel = v.sel; bus.Stall = v.stall;
        bus.BranchEn = v.br; bus.CondSel = v.cond; bus.GE_Flag = v.ge;
        bus.EQ_Flag = v.eq; bus.BranchOffset = v.off; bus.CallEn = v.call;
        bus.RetEn = v.ret; bus.HaltEn = v.halt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t idle_v;

    initial begin
        idle_v = mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,0,0,0, 10'd0,3'd0,0,0,0);
        //       st sel stl br cond        ge eq off       ca re ha  pc       cnt ov un dn
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd1,   3'd0,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd2,   3'd0,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd3,   3'd0,0,0,0));
        vq.push_back(mk(0,0,0,1,COND_ALWAYS,0,0,5'd7,    0,0,0, 10'd10,  3'd0,0,0,0));
        vq.push_back(mk(0,0,0,1,COND_GE,    1,0,5'b11100,0,0,0, 10'd6,   3'd0,0,0,0));
        vq.push_back(mk(0,0,0,1,COND_ALWAYS,0,0,5'd4,    0,0,0, 10'd10,  3'd0,0,0,0));
        vq.push_back(mk(0,0,0,1,COND_GE,    0,0,5'b11100,0,0,0, 10'd11,  3'd0,0,0,0));
        vq.push_back(mk(0,0,0,1,COND_ALWAYS,0,0,5'b11111,0,0,0, 10'd10,  3'd0,0,0,0));
        vq.push_back(mk(0,0,0,1,COND_EQ,    0,1,5'b11100,0,0,0, 10'd6,   3'd0,0,0,0));
        vq.push_back(mk(0,0,0,1,COND_NGE,   1,0,5'd13,   0,0,0, 10'd7,   3'd0,0,0,0));
        vq.push_back(mk(0,0,0,1,COND_NGE,   0,0,5'd13,   0,0,0, 10'd20,  3'd0,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd8,    1,0,0, 10'd28,  3'd1,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,1,0, 10'd21,  3'd0,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,1,0, 10'd22,  3'd0,0,1,0));
        vq.push_back(mk(0,0,1,1,COND_ALWAYS,0,0,5'd8,    1,0,0, 10'd22,  3'd0,0,1,0));
        vq.push_back(mk(0,0,0,1,COND_ALWAYS,0,0,5'd8,    1,1,0, 10'd23,  3'd0,0,1,0));
        vq.push_back(mk(1,1,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd100, 3'd0,0,0,0));
        vq.push_back(mk(1,1,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd100, 3'd0,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd100, 3'd0,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd101, 3'd0,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd2,    1,0,0, 10'd103, 3'd1,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd2,    1,0,0, 10'd105, 3'd2,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd2,    1,0,0, 10'd107, 3'd3,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd2,    1,0,0, 10'd109, 3'd4,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd2,    1,0,0, 10'd111, 3'd4,1,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,1,0, 10'd110, 3'd3,1,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,1,0, 10'd108, 3'd2,1,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,1,0, 10'd106, 3'd1,1,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,1,0, 10'd104, 3'd0,1,0,0));
        vq.push_back(mk(1,0,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd0,   3'd0,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd0,   3'd0,0,0,0));
        vq.push_back(mk(0,0,0,1,COND_ALWAYS,0,0,5'b11111,0,0,0, 10'd1023,3'd0,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd0,   3'd0,0,0,0));
        vq.push_back(mk(0,0,0,1,COND_ALWAYS,0,0,5'd5,    0,0,0, 10'd5,   3'd0,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,0,1, 10'd5,   3'd0,0,0,1));
        vq.push_back(mk(0,0,0,1,COND_ALWAYS,0,0,5'd3,    0,0,0, 10'd5,   3'd0,0,0,1));
        vq.push_back(mk(0,0,1,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd5,   3'd0,0,0,1));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd3,    1,1,0, 10'd5,   3'd0,0,0,1));
        vq.push_back(mk(1,2,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd200, 3'd0,0,0,0));
        vq.push_back(mk(1,2,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd200, 3'd0,0,0,0));
        vq.push_back(mk(0,0,1,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd200, 3'd0,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd200, 3'd0,0,0,0));
        vq.push_back(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,    0,0,0, 10'd201, 3'd0,0,0,0));

        rst = 1'b1;
        drive(idle_v);
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i]);
            step();
            chk_all($sformatf("v%0d", i), int'(vq[i].pc), int'(vq[i].cnt),
                    int'(vq[i].ovf), int'(vq[i].unf), int'(vq[i].done));
        end

        // Reset while a call is being issued discards the pushed entry.
        drive(mk(0,0,0,0,COND_ALWAYS,0,0,5'd3,1,0,0, 10'd0,3'd0,0,0,0));
        step();
        chk_all("call_pre_rst", 204, 1, 0, 0, 0);
        rst = 1'b1;
        step();
        chk_all("rst_mid_call", 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,0,1,0, 10'd0,3'd0,0,0,0));
        step();
        chk_all("ret_after_rst", 1, 0, 0, 1, 0);

        // Reset out of HALT, then normal counting resumes.
        drive(mk(0,0,0,0,COND_ALWAYS,0,0,5'd0,0,0,1, 10'd0,3'd0,0,0,0));
        step();
        chk_all("halt_again", 1, 0, 0, 1, 1);
        drive(idle_v);
        rst = 1'b1;
        step();
        chk_all("rst_from_halt", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        chk_all("run_after_rst", 1, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
